id_ex_pipe_reg: RTL and testbench

//  ID->EX pipeline register with valid/ready handshake, stall and flush.

---
 rtl/id_ex_pipe_reg_pkg.sv | 24 ++
 rtl/id_ex_pipe_reg_if.sv | 39 +++
 rtl/id_ex_slot.sv | 57 +++++
 rtl/id_ex_pipe_reg.sv | 108 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg_pkg
// Shared constants for the ID->EX pipeline register slice.
//   PC_W_DEF / DATA_W_DEF / RADDR_W_DEF : default payload field widths
//   SHIFT_TYPE_W                        : width of the shift-type field
//   SHIFT_NONE                          : shift-type encoding for "no shift"
//   payload_w()                         : packed payload width for given widths
// Payload packing order (MSB..LSB): pc, op1, op2, word_op, shift_type, rd, rd_wen
// ----------------------------------------------------------------------------
package id_ex_pipe_reg_pkg;

    localparam int PC_W_DEF     = 64;
    localparam int DATA_W_DEF   = 64;
    localparam int RADDR_W_DEF  = 5;
    localparam int SHIFT_TYPE_W = 3;

    localparam logic [SHIFT_TYPE_W-1:0] SHIFT_NONE = 3'b000;

    // pc + op1 + op2 + word_op + shift_type + rd + rd_wen
    function automatic int payload_w(int pc_w, int data_w, int raddr_w);
        return pc_w + 2 * data_w + 1 + SHIFT_TYPE_W + raddr_w + 1;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Valid/ready handshake plus decoded payload between two pipeline stages.
//   valid      : producer holds an instruction
//   ready      : consumer accepts this cycle
//   pc         : instruction pc
//   op1 / op2  : operands (op1 = rs1 / shifted data, op2 = rs2/imm / shamt)
//   word_op    : RV64 *W instruction
//   shift_type : shift kind, SHIFT_NONE = no shift
//   rd / rd_wen: destination register and its write enable
// Modports: master = producer (drives valid + payload), slave = consumer.
// ----------------------------------------------------------------------------
interface id_ex_pipe_reg_if import id_ex_pipe_reg_pkg::*; #(
    parameter int PC_W    = PC_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) ();

    logic                    valid;
    logic                    ready;
    logic [PC_W-1:0]         pc;
    logic [DATA_W-1:0]       op1;
    logic [DATA_W-1:0]       op2;
    logic                    word_op;
    logic [SHIFT_TYPE_W-1:0] shift_type;
    logic [RADDR_W-1:0]      rd;
    logic                    rd_wen;

    modport master (
        output valid, pc, op1, op2, word_op, shift_type, rd, rd_wen,
        input  ready
    );

    modport slave (
        input  valid, pc, op1, op2, word_op, shift_type, rd, rd_wen,
        output ready
    );

endinterface

// File: rtl/id_ex_slot.sv
// ----------------------------------------------------------------------------
// id_ex_slot
// One payload register plus its valid bit.
//   clk, rst  : clock, synchronous active-high reset (valid and payload -> 0)
//   clear_i   : flush; valid -> 0, payload ANDed with CLR_MASK
//   load_i    : capture d_i, valid -> 1
//   drain_i   : entry consumed with nothing to replace it; valid -> 0,
//               payload holds its value
//   valid_o   : entry occupied
//   q_o       : registered payload
// Priority: rst > clear_i > load_i > drain_i.
// ----------------------------------------------------------------------------
module id_ex_slot #(
    parameter int           W        = 8,
    parameter logic [W-1:0] CLR_MASK = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d,  data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = data_q & CLR_MASK;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg
// ID->EX pipeline register with valid/ready handshake, stall and flush.
//   clk           : rising-edge clock
//   rst           : synchronous active-high reset
//   id_ex_flush_i : drop every held entry (branch redirect / trap)
//   id_ex_in      : slave side from ID (valid, payload in; ready out)
//   id_ex_out     : master side to EX (valid, payload out; ready in)
// Word ops get op1 sign-extended from bit 31 at capture; the EX shifter
// depends on seeing the already-extended value.
// Build option: define ID_EX_SKID_EN for a two-entry (main + skid) version
// whose ready is a registered output; without it, a single entry with
// ready = ~valid | downstream ready (combinational ready path).
// ----------------------------------------------------------------------------
module id_ex_pipe_reg import id_ex_pipe_reg_pkg::*; #(
    parameter int PC_W    = PC_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_flush_i,
    id_ex_pipe_reg_if.slave  id_ex_in,
    id_ex_pipe_reg_if.master id_ex_out
);

    localparam int PAYLOAD_W = payload_w(PC_W, DATA_W, RADDR_W);
    // rd_wen sits at bit 0; flush clears only that bit so no stale writeback
    // can be observed, everything else keeps its last value.
    localparam logic [PAYLOAD_W-1:0] CLR_MASK = {{(PAYLOAD_W-1){1'b1}}, 1'b0};

    logic [DATA_W-1:0]    op1_ext;
    logic [PAYLOAD_W-1:0] in_pl;
    logic [PAYLOAD_W-1:0] main_d;
    logic [PAYLOAD_W-1:0] main_pl;
    logic                 main_valid;
    logic                 main_load;
    logic                 main_drain;
    logic                 ready_o;
    logic                 in_fire;
    logic                 out_fire;

    assign op1_ext = id_ex_in.word_op
                   ? {{(DATA_W-32){id_ex_in.op1[31]}}, id_ex_in.op1[31:0]}
                   : id_ex_in.op1;

    assign in_pl = {id_ex_in.pc, op1_ext, id_ex_in.op2, id_ex_in.word_op,
                    id_ex_in.shift_type, id_ex_in.rd, id_ex_in.rd_wen};

    assign out_fire = main_valid & id_ex_out.ready;

`ifdef ID_EX_SKID_EN
    logic [PAYLOAD_W-1:0] skid_pl;
    logic                 skid_valid;
    logic                 skid_load;
    logic                 skid_drain;
    logic                 main_free;

    // ready depends only on skid occupancy: registered, no ready_i path.
    assign ready_o   = ~skid_valid;
    assign in_fire   = id_ex_in.valid & ready_o;
    assign main_free = ~main_valid | out_fire;

    // Skid is older than anything arriving now, so it refills main first.
    assign main_load  = main_free & (skid_valid | in_fire);
    assign main_d     = skid_valid ? skid_pl : in_pl;
    assign main_drain = out_fire;

    // Input parks in skid only while main is stuck; skid holds at most one
    // because ready drops as soon as it is occupied.
    assign skid_load  = in_fire & ~main_free;
    assign skid_drain = skid_valid & main_free;

    id_ex_slot #(.W(PAYLOAD_W), .CLR_MASK(CLR_MASK)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (id_ex_flush_i),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .d_i     (in_pl),
        .valid_o (skid_valid),
        .q_o     (skid_pl)
    );
`else
    assign ready_o    = ~main_valid | id_ex_out.ready;
    assign in_fire    = id_ex_in.valid & ready_o;
    assign main_load  = in_fire;
    assign main_d     = in_pl;
    assign main_drain = out_fire;
`endif

    id_ex_slot #(.W(PAYLOAD_W), .CLR_MASK(CLR_MASK)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear_i (id_ex_flush_i),
        .load_i  (main_load),
        .drain_i (main_drain),
        .d_i     (main_d),
        .valid_o (main_valid),
        .q_o     (main_pl)
    );

    assign id_ex_in.ready  = ready_o;
    assign id_ex_out.valid = main_valid;
    assign {id_ex_out.pc, id_ex_out.op1, id_ex_out.op2, id_ex_out.word_op,
            id_ex_out.shift_type, id_ex_out.rd, id_ex_out.rd_wen} = main_pl;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;
    import id_ex_pipe_reg_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        word_op;
        logic [2:0]  shift_type;
        logic [4:0]  rd;
        logic        rd_wen;
    } pl_t;

    typedef struct {
        logic [63:0] op1;
        logic        word_op;
        logic [63:0] exp_op1;
    } vec_t;

`ifdef ID_EX_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    id_ex_pipe_reg_if in_if ();
    id_ex_pipe_reg_if out_if ();

    id_ex_pipe_reg dut (
        .clk           (clk),
        .rst           (rst),
        .id_ex_flush_i (flush),
        .id_ex_in      (in_if),
        .id_ex_out     (out_if)
    );

    int          checks = 0;
    int          failures = 0;
    pl_t         q[$];        // entries held by the stage, oldest first
    pl_t         held;        // what the payload outputs should show
    logic [63:0] outs[$];     // pcs observed on output transfers

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic pl_t captured();
        pl_t p;
        p.pc         = in_if.pc;
        p.op1        = in_if.word_op ? {{32{in_if.op1[31]}}, in_if.op1[31:0]} : in_if.op1;
        p.op2        = in_if.op2;
        p.word_op    = in_if.word_op;
        p.shift_type = in_if.shift_type;
        p.rd         = in_if.rd;
        p.rd_wen     = in_if.rd_wen;
        return p;
    endfunction

    // Single entry: accepts when empty or when the held one leaves this cycle.
    // Two entries: accepts whenever fewer than two are held.
    function automatic logic model_ready();
        if (DEPTH == 2) return q.size() < 2;
        return (q.size() == 0) || out_if.ready;
    endfunction

    task automatic model_update();
        logic in_f, out_f;
        in_f  = in_if.valid && model_ready();
        out_f = (q.size() > 0) && out_if.ready;
        if (rst) begin
            q.delete();
            held = '0;
        end else if (flush) begin
            q.delete();
            held.rd_wen = 1'b0;
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f)  q.push_back(captured());
        end
        if (q.size() > 0) held = q[0];
    endtask

    task automatic check_outputs();
        chk("valid_o", out_if.valid, q.size() > 0);
        if (!flush && !rst) chk("ready_o", in_if.ready, model_ready());
        chk("pc_o", out_if.pc, held.pc);
        chk("op1_o", out_if.op1, held.op1);
        chk("op2_o", out_if.op2, held.op2);
        chk("word_op_o", out_if.word_op, held.word_op);
        chk("shift_type_o", out_if.shift_type, held.shift_type);
        chk("rd_o", out_if.rd, held.rd);
        chk("rd_wen_o", out_if.rd_wen, held.rd_wen);
        if (out_if.valid && out_if.ready && !flush && !rst) outs.push_back(out_if.pc);
    endtask

    // Inputs are set at the negedge; check, clock, update model, return at negedge.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(logic v, logic [63:0] pc, logic [63:0] op1, logic w);
        in_if.valid      = v;
        in_if.pc         = pc;
        in_if.op1        = op1;
        in_if.op2        = pc * 3;
        in_if.word_op    = w;
        in_if.shift_type = pc[4:2];
        in_if.rd         = pc[8:4];
        in_if.rd_wen     = 1'b1;
    endtask

    task automatic drain();
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        outs.delete();
    endtask

    vec_t tbl[5];

    initial begin
        logic [63:0] pc, hold_pc;
        int          n_sent, cnt;
        logic        acc, r0;

        tbl[0] = '{64'h0000_0000_8000_0001, 1'b1, 64'hFFFF_FFFF_8000_0001};
        tbl[1] = '{64'h0000_0000_8000_0001, 1'b0, 64'h0000_0000_8000_0001};
        tbl[2] = '{64'h1234_5678_7FFF_FFFF, 1'b1, 64'h0000_0000_7FFF_FFFF};
        tbl[3] = '{64'hFFFF_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000};
        tbl[4] = '{64'hDEAD_BEEF_FFFF_FFFE, 1'b0, 64'hDEAD_BEEF_FFFF_FFFE};

        held = '0;
        rst = 1'b1;
        flush = 1'b0;
        out_if.ready = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Reset values
        #1;
        chk("rst_valid", out_if.valid, 1'b0);
        chk("rst_shift", out_if.shift_type, SHIFT_NONE);
        chk("rst_rd_wen", out_if.rd_wen, 1'b0);
        chk("rst_ready", in_if.ready, 1'b1);
        chk("rst_pc", out_if.pc, 64'h0);

        // Word-op sign extension table
        out_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h40 + 64'(i * 4), tbl[i].op1, tbl[i].word_op);
            step();
            #1 chk("word_ext_op1", out_if.op1, tbl[i].exp_op1);
        end

        // Stall: ready_i low 5 cycles while ID streams
        drain();
        pc = 64'h100;
        out_if.ready = 1'b0;
        hold_pc = 64'h100;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pc, pc, 1'b0);
            acc = model_ready();
            step();
            if (acc) pc += 4;
            #1 chk("stall_hold_pc", out_if.pc, hold_pc);
        end
        out_if.ready = 1'b1;
        while (pc < 64'h120) begin
            drive(1'b1, pc, pc, 1'b0);
            acc = model_ready();
            step();
            if (acc) pc += 4;
        end
        n_sent = int'((pc - 64'h100) >> 2);
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        step();
        chk("stall_out_count", outs.size(), n_sent);
        for (int i = 0; i < outs.size(); i++)
            chk("stall_order", outs[i], 64'h100 + 64'(i * 4));

        // Flush while full with a simultaneous input
        drain();
        drive(1'b1, 64'h500, 64'h5, 1'b0);
        step();
        out_if.ready = 1'b0;
        drive(1'b1, 64'h504, 64'h6, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 64'hDEAD0, 64'h7, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        #1;
        chk("flush_valid", out_if.valid, 1'b0);
        chk("flush_rd_wen", out_if.rd_wen, 1'b0);
        out_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        cnt = 0;
        foreach (outs[i]) if (outs[i] == 64'hDEAD0) cnt++;
        chk("flush_dropped", cnt, 0);

        // Throughput: 100 instrs, 101 cycles
        drain();
        for (int i = 0; i < 101; i++) begin
            drive(i < 100, 64'h1000 + 64'(i * 4), 64'(i), 1'b0);
            step();
        end
        chk("tput_count", outs.size(), 100);
        cnt = 0;
        foreach (outs[i]) if (outs[i] != 64'h1000 + 64'(i * 4)) cnt++;
        chk("tput_order_errs", cnt, 0);

        // Reset in the middle of a stall
        drain();
        out_if.ready = 1'b0;
        drive(1'b1, 64'h700, 64'h1, 1'b0);
        step();
        step();
        rst = 1'b1;
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", out_if.valid, 1'b0);
        chk("midrst_rd_wen", out_if.rd_wen, 1'b0);
        chk("midrst_pc", out_if.pc, 64'h0);

`ifdef ID_EX_SKID_EN
        // ready_o must not follow ready_i within a cycle
        for (int i = 0; i < 4; i++) begin
            out_if.ready = 1'b0;
            drive(1'b1, 64'h900 + 64'(i * 4), 64'h0, 1'b0);
            #1 r0 = in_if.ready;
            out_if.ready = 1'b1;
            #1 chk("ready_no_comb", in_if.ready, r0);
            out_if.ready = 1'b0;
            step();
        end
`endif

        // Random valid/ready/flush against the queue model
        for (int i = 0; i < 10000; i++) begin
            rst          = ($urandom_range(499) == 0);
            flush        = ($urandom_range(31) == 0);
            out_if.ready = ($urandom_range(9) < 6);
            in_if.valid      = ($urandom_range(9) < 7);
            in_if.pc         = {$urandom, $urandom};
            in_if.op1        = {$urandom, $urandom};
            in_if.op2        = {$urandom, $urandom};
            in_if.word_op    = $urandom_range(1);
            in_if.shift_type = 3'($urandom_range(7));
            in_if.rd         = 5'($urandom_range(31));
            in_if.rd_wen     = $urandom_range(1);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
